rptr_and_empty: RTL and testbench



---
 rtl/fifo_pkg.sv | 16 +
 rtl/gray2bin_conv.sv | 11 +
 rtl/rptr_and_empty.sv | 52 +++++
 tb/tb_rptr_and_empty.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared async-FIFO constants and width-agnostic Gray/binary helpers.
package fifo_pkg;
    localparam int default_addr_width = 3;
    localparam int max_w = 32;

    function automatic logic [max_w-1:0] bin2gray(input logic [max_w-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [max_w-1:0] gray2bin(input logic [max_w-1:0] g);
        logic [max_w-1:0] b;
        b[max_w-1] = g[max_w-1];
        for (int i = max_w-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/gray2bin_conv.sv
// gray2bin_conv: combinational Gray-to-binary converter of configurable width.
module gray2bin_conv
    import fifo_pkg::*;
#(
    parameter int width = default_addr_width + 1
) (
    input  logic [width-1:0] gray,
    output logic [width-1:0] bin
);
    always_comb bin = width'(gray2bin(max_w'(gray)));
endmodule

// File: rtl/rptr_and_empty.sv
// rptr_and_empty: read-domain pointer, RAM read address and registered empty/almost-empty/occupancy/underflow.
module rptr_and_empty
    import fifo_pkg::*;
#(
    parameter int addr_width = default_addr_width
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  rinc,
    input  logic [addr_width:0]   rq2_wptr,
    input  logic [addr_width:0]   ae_level,
    output logic [addr_width:0]   rptr,
    output logic [addr_width-1:0] raddr,
    output logic                  rempty,
    output logic                  ralmost_empty,
    output logic [addr_width:0]   rcount,
    output logic                  runderflow
);
    localparam int pw = addr_width + 1;

    logic [pw-1:0] rbin, rbin_next, rgray_next, wbin_s, count_next;
    logic          rd_ok;

    gray2bin_conv #(.width(pw)) u_wconv (.gray(rq2_wptr), .bin(wbin_s));

    always_comb begin
        rd_ok      = rinc & ~rempty;
        rbin_next  = rbin + pw'(rd_ok);
        rgray_next = pw'(bin2gray(max_w'(rbin_next)));
        count_next = wbin_s - rbin_next;
    end

    assign raddr = rbin[addr_width-1:0];

    // Full-width Gray compare: same address on a different lap is not empty.
    always_ff @(posedge rclk or posedge rrst)
        if (rrst) begin
            rbin          <= '0;
            rptr          <= '0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            rcount        <= '0;
            runderflow    <= 1'b0;
        end else begin
            rbin          <= rbin_next;
            rptr          <= rgray_next;
            rempty        <= rgray_next == rq2_wptr;
            rcount        <= count_next;
            ralmost_empty <= count_next <= ae_level;
            runderflow    <= runderflow | (rinc & rempty);
        end
endmodule

// File: tb/tb_rptr_and_empty.sv
// tb_rptr_and_empty: directed stimulus, occupancy-level reference model plus literal spot checks.
module tb_rptr_and_empty;
    logic       rclk = 0;
    logic       rrst = 1;
    logic       rinc = 0;
    logic [3:0] rq2_wptr = 0;
    logic [3:0] ae_level = 0;
    logic [3:0] rptr;
    logic [2:0] raddr;
    logic       rempty, ralmost_empty, runderflow;
    logic [3:0] rcount;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    int   m_rb, m_cnt;
    logic m_empty, m_ae, m_uf;

    rptr_and_empty #(.addr_width(3)) dut (
        .rclk(rclk), .rrst(rrst), .rinc(rinc), .rq2_wptr(rq2_wptr), .ae_level(ae_level),
        .rptr(rptr), .raddr(raddr), .rempty(rempty), .ralmost_empty(ralmost_empty),
        .rcount(rcount), .runderflow(runderflow)
    );

    always #5 rclk = ~rclk;

    function automatic logic [3:0] b2g(input int b);
        return 4'(b ^ (b >> 1));
    endfunction

    // Inverse by search over all pointer values.
    function automatic int g2b(input logic [3:0] g);
        for (int b = 0; b < 16; b++) if (b2g(b) == g) return b;
        return 0;
    endfunction

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    // Model tracks read count and write position; empty means they coincide.
    always @(posedge rclk or posedge rrst)
        if (rrst) begin
            m_rb <= 0; m_cnt <= 0; m_empty <= 1; m_ae <= 1; m_uf <= 0;
        end else begin
            int wb, nb, c;
            wb = g2b(rq2_wptr);
            nb = (m_rb + ((rinc && !m_empty) ? 1 : 0)) % 16;
            c = (wb - nb + 16) % 16;
            m_rb <= nb;
            m_cnt <= c;
            m_empty <= (c == 0);
            m_ae <= (c <= int'(ae_level));
            m_uf <= m_uf | (rinc & m_empty);
        end

    always @(negedge rclk)
        if (chk_en) begin
            chk("rptr", 8'(rptr), 8'(b2g(m_rb)));
            chk("raddr", 8'(raddr), 8'(m_rb % 8));
            chk("rempty", 8'(rempty), 8'(m_empty));
            chk("ralmost_empty", 8'(ralmost_empty), 8'(m_ae));
            chk("rcount", 8'(rcount), 8'(m_cnt));
            chk("runderflow", 8'(runderflow), 8'(m_uf));
        end

    task automatic step(input logic inc, input logic [3:0] w);
        rinc = inc;
        rq2_wptr = w;
        @(negedge rclk); #1;
    endtask

    initial begin
        rrst = 1; rinc = 1; rq2_wptr = 0; ae_level = 0;
        repeat (3) @(negedge rclk);
        #1;
        chk_en = 1;
        chk("rst_rptr", 8'(rptr), 8'h0);
        chk("rst_raddr", 8'(raddr), 8'h0);
        chk("rst_rempty", 8'(rempty), 8'h1);
        chk("rst_ralmost", 8'(ralmost_empty), 8'h1);
        chk("rst_rcount", 8'(rcount), 8'h0);
        chk("rst_runderflow", 8'(runderflow), 8'h0);
        rinc = 0;
        rrst = 0;
        step(0, 4'b0000);
        step(0, 4'b0000);
        chk("hold_rempty", 8'(rempty), 8'h1);
        chk("hold_rptr", 8'(rptr), 8'h0);

        // fill to 3 then drain
        step(0, 4'b0010);
        chk("fill_rempty", 8'(rempty), 8'h0);
        chk("fill_rcount", 8'(rcount), 8'h3);
        chk("drain_raddr0", 8'(raddr), 8'h0);
        step(1, 4'b0010);
        chk("drain_rptr1", 8'(rptr), 8'b0001);
        chk("drain_raddr1", 8'(raddr), 8'h1);
        step(1, 4'b0010);
        chk("drain_rptr2", 8'(rptr), 8'b0011);
        chk("drain_raddr2", 8'(raddr), 8'h2);
        step(1, 4'b0010);
        chk("drain_rptr3", 8'(rptr), 8'b0010);
        chk("drain_rempty", 8'(rempty), 8'h1);
        chk("drain_rcount", 8'(rcount), 8'h0);

        // underflow
        step(1, 4'b0010);
        chk("uf_rptr", 8'(rptr), 8'b0010);
        chk("uf_flag", 8'(runderflow), 8'h1);
        step(0, 4'b0010);
        chk("uf_sticky", 8'(runderflow), 8'h1);

        // wrap through bin 7 -> 8
        for (int w = 4; w <= 9; w++) begin
            step(0, b2g(w));
            step(1, b2g(w));
            if (w == 7) begin
                chk("wrap_rptr7", 8'(rptr), 8'b0100);
                chk("wrap_raddr7", 8'(raddr), 8'b111);
            end
            if (w == 8) begin
                chk("wrap_rptr8", 8'(rptr), 8'b1100);
                chk("wrap_raddr8", 8'(raddr), 8'b000);
            end
        end
        chk("wrap_rptr9", 8'(rptr), 8'b1101);
        chk("wrap_rempty", 8'(rempty), 8'h1);

        // equal address, different lap: full
        step(0, 4'b0001);
        chk("lap_rempty", 8'(rempty), 8'h0);
        chk("lap_rcount", 8'(rcount), 8'h8);

        // almost-empty from a fresh pointer
        @(negedge rclk); #3;
        rrst = 1;
        #1;
        rrst = 0;
        ae_level = 2;
        step(0, 4'b0110);
        chk("ae_rcount4", 8'(rcount), 8'h4);
        chk("ae_flag4", 8'(ralmost_empty), 8'h0);
        chk("ae_uf_cleared", 8'(runderflow), 8'h0);
        step(1, 4'b0110);
        chk("ae_flag3", 8'(ralmost_empty), 8'h0);
        step(1, 4'b0110);
        chk("ae_rcount2", 8'(rcount), 8'h2);
        chk("ae_flag2", 8'(ralmost_empty), 8'h1);

        // read concurrent with write advance
        step(1, 4'b0110);
        chk("sim_pre_rcount", 8'(rcount), 8'h1);
        step(1, 4'b0111);
        chk("sim_rcount", 8'(rcount), 8'h1);
        chk("sim_rempty", 8'(rempty), 8'h0);
        chk("sim_rptr", 8'(rptr), 8'b0110);

        // async reset mid-stream
        step(0, 4'b1101);
        chk("mid_rcount", 8'(rcount), 8'h5);
        rinc = 1;
        #2;
        rrst = 1;
        #1;
        chk("arst_rptr", 8'(rptr), 8'h0);
        chk("arst_rempty", 8'(rempty), 8'h1);
        chk("arst_rcount", 8'(rcount), 8'h0);
        chk("arst_ralmost", 8'(ralmost_empty), 8'h1);
        chk("arst_raddr", 8'(raddr), 8'h0);
        repeat (2) @(negedge rclk);
        #1;
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
